// File: rtl/spi_tgt_pkg.sv
// spi_tgt_pkg: shared FSM state type, sync byte and command field positions for spi_target_regs
package spi_tgt_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int RW_BIT = 7;
    localparam int ADDR_LSB = 0;
endpackage

// File: rtl/spi_tgt_sync.sv
// spi_tgt_sync: N-stage synchronizer with one-cycle rise/fall pulses
// Ports: i_clk, i_rst (async, active-high), i_d async input, o_rise/o_fall event pulses.
module spi_tgt_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_hist;
    logic              w_q;
    // Chain resets low so a CS_n already low at reset release produces no fall event.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_hist <= w_q;
        end
    end
    assign w_q    = r_sync[STAGES-1];
    assign o_rise = w_q & ~r_hist;
    assign o_fall = ~w_q & r_hist;
endmodule

// File: rtl/spi_target_regs.sv
// spi_target_regs: SPI mode-0 target serving a 16 x 8 register file, plus a local access port
// Ports: wb_clk_i/wb_rst_i (async, active-high); spi_sck_i, spi_cs_n_i, spi_mosi_i in,
// spi_miso_o/spi_miso_oe_o out; loc_addr_i/loc_wdata_i/loc_we_i local write, loc_rdata_o
// combinational read; spi_wr_o/spi_wr_addr_o report SPI writes; busy_o while not IDLE.
// Define SPI_TGT_AUTOINC_EN to auto-increment the address after every data byte.
module spi_target_regs
    import spi_tgt_pkg::*;
#(
    parameter int REG_COUNT   = 16,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              spi_sck_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    input  logic [ADDR_W-1:0] loc_addr_i,
    input  logic [7:0]        loc_wdata_i,
    input  logic              loc_we_i,
    output logic [7:0]        loc_rdata_o,
    output logic              spi_wr_o,
    output logic [ADDR_W-1:0] spi_wr_addr_o,
    output logic              busy_o
);
`ifdef SPI_TGT_AUTOINC_EN
    localparam int AUTOINC = 1;
`else
    localparam int AUTOINC = 0;
`endif
    logic [7:0]             r_regs [REG_COUNT];
    state_t                 r_state;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_rx;
    logic [7:0]             r_tx, r_tx_next;
    logic                   r_rw, r_byte_done, r_wr;
    logic [ADDR_W-1:0]      r_addr, r_wr_addr;
    logic [SYNC_STAGES-1:0] r_mosi;
    logic                   w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_last;
    logic [7:0]             w_rx_byte;
    logic [ADDR_W-1:0]      w_cmd_addr, w_next_addr;
    spi_tgt_sync #(.STAGES(SYNC_STAGES)) u_sck (
        .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_d(spi_sck_i), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    spi_tgt_sync #(.STAGES(SYNC_STAGES)) u_cs (
        .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_d(spi_cs_n_i), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    assign w_rx_byte   = {r_rx, r_mosi[SYNC_STAGES-1]};
    assign w_last      = r_bit_cnt == 3'd7;
    assign w_cmd_addr  = w_rx_byte[ADDR_LSB +: ADDR_W];
    assign w_next_addr = r_addr + ADDR_W'(AUTOINC);
    // Local write is issued first so a same-cycle SPI write to the same address overrides it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= 8'h00;
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx        <= 7'd0;
            r_tx        <= 8'h00;
            r_tx_next   <= 8'h00;
            r_rw        <= 1'b0;
            r_byte_done <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wr_addr   <= '0;
            r_mosi      <= '0;
        end else begin
            r_mosi <= {r_mosi[SYNC_STAGES-2:0], spi_mosi_i};
            r_wr   <= 1'b0;
            if (loc_we_i) r_regs[loc_addr_i] <= loc_wdata_i;
            if (w_cs_rise) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state     <= CMD;
                            r_bit_cnt   <= 3'd0;
                            r_tx        <= SYNC_BYTE;
                            r_byte_done <= 1'b0;
                        end
                    end
                    CMD, DATA: begin
                        if (w_sck_rise) begin
                            r_rx      <= w_rx_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last) begin
                                r_byte_done <= 1'b1;
                                if (r_state == CMD) begin
                                    r_state   <= DATA;
                                    r_rw      <= w_rx_byte[RW_BIT];
                                    r_addr    <= w_cmd_addr;
                                    r_tx_next <= w_rx_byte[RW_BIT] ? r_regs[w_cmd_addr] : 8'h00;
                                end else if (r_rw) begin
                                    r_addr    <= w_next_addr;
                                    r_tx_next <= r_regs[w_next_addr];
                                end else begin
                                    r_regs[r_addr] <= w_rx_byte;
                                    r_wr           <= 1'b1;
                                    r_wr_addr      <= r_addr;
                                    r_addr         <= w_next_addr;
                                end
                            end
                        end
                        // The first fall after a byte boundary presents the next byte's MSB.
                        if (w_sck_fall) begin
                            r_tx        <= r_byte_done ? r_tx_next : {r_tx[6:0], 1'b0};
                            r_byte_done <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
    assign spi_miso_o    = r_tx[7];
    assign spi_miso_oe_o = r_state != IDLE;
    assign busy_o        = r_state != IDLE;
    assign spi_wr_o      = r_wr;
    assign spi_wr_addr_o = r_wr_addr;
    assign loc_rdata_o   = r_regs[loc_addr_i];
endmodule

// File: tb/tb_spi_target_regs.sv
// tb_spi_target_regs: randomized scoreboard bench for spi_target_regs against a register-array model
module tb_spi_target_regs;
    localparam int HALF = 8;
    localparam int SS = 2;
`ifdef SPI_TGT_AUTOINC_EN
    localparam int INC = 1;
`else
    localparam int INC = 0;
`endif
    logic clk = 1'b0, rst = 1'b1, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0, loc_we = 1'b0;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_wdata = 8'h00;
    logic miso, oe, wr, busy;
    logic [3:0] wr_addr;
    logic [7:0] loc_rdata;
    int n_vec = 0, n_err = 0;
    logic [7:0] model [16];
    logic [7:0] exp_miso [$];
    logic [3:0] exp_wr [$];
    logic mon_en = 1'b1;
    logic [7:0] m_sh = 8'h00;
    int m_cnt = 0;

    always #5 clk = ~clk;

    spi_target_regs #(.REG_COUNT(16), .ADDR_W(4), .SYNC_STAGES(SS)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .spi_sck_i(sck), .spi_cs_n_i(cs_n), .spi_mosi_i(mosi),
        .spi_miso_o(miso), .spi_miso_oe_o(oe), .loc_addr_i(loc_addr), .loc_wdata_i(loc_wdata),
        .loc_we_i(loc_we), .loc_rdata_o(loc_rdata), .spi_wr_o(wr), .spi_wr_addr_o(wr_addr), .busy_o(busy)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // MISO monitor: assembles bytes as the master samples them and checks against the queue.
    always @(posedge sck or posedge cs_n) begin
        if (cs_n) m_cnt = 0;
        else if (mon_en) begin
            m_sh = {m_sh[6:0], miso};
            m_cnt++;
            if (m_cnt == 8) begin
                m_cnt = 0;
                if (exp_miso.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL miso_unexpected: got %h expected no byte", m_sh);
                end else chk("miso_byte", m_sh, exp_miso.pop_front());
            end
        end
    end

    // Write-report monitor.
    always @(negedge clk) begin
        if (!rst && wr) begin
            if (exp_wr.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spi_wr_unexpected: got addr %h expected no pulse", wr_addr);
            end else chk("spi_wr_addr", 8'(wr_addr), 8'(exp_wr.pop_front()));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        wait_n(HALF);
    endtask

    task automatic cs_high();
        wait_n(HALF);
        cs_n = 1'b1;
        wait_n(2 * HALF);
    endtask

    task automatic send_bit(input logic b, input logic coll, input logic [3:0] ca, input logic [7:0] cd);
        mosi = b;
        wait_n(HALF);
        sck = 1'b1;
        if (coll) begin
            repeat (SS) @(posedge clk);
            @(negedge clk);
            loc_addr = ca;
            loc_wdata = cd;
            loc_we = 1'b1;
            @(negedge clk);
            loc_we = 1'b0;
            wait_n(HALF - 2);
        end else wait_n(HALF);
        sck = 1'b0;
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        loc_addr = a;
        loc_wdata = d;
        loc_we = 1'b1;
        @(negedge clk);
        loc_we = 1'b0;
        model[a] = d;
    endtask

    task automatic check_reg(input logic [3:0] a);
        @(negedge clk);
        loc_addr = a;
        #1;
        chk($sformatf("reg%0d", a), loc_rdata, model[a]);
    endtask

    // Expected responses follow the command rules directly: sync byte first, then either the
    // addressed registers (reads) or zeros with register updates (writes); only whole bytes count.
    task automatic spi_xfer(input logic [7:0] b [$], input int nbits, input logic coll,
                            input logic [3:0] ca, input logic [7:0] cd);
        int nfull;
        logic [3:0] a;
        logic [7:0] t;
        nfull = nbits / 8;
        a = b[0][3:0];
        exp_miso.push_back(8'hA5);
        for (int j = 1; j < nfull; j++) begin
            if (b[0][7]) exp_miso.push_back(model[a]);
            else begin
                exp_miso.push_back(8'h00);
                if (coll && j == nfull - 1) model[ca] = cd;
                model[a] = b[j];
                exp_wr.push_back(a);
            end
            a = a + 4'(INC);
        end
        cs_low();
        for (int i = 0; i < nbits; i++) begin
            t = b[i / 8];
            send_bit(t[7 - (i % 8)], coll && i == nbits - 1, ca, cd);
        end
        cs_high();
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] cmd;
        int nb, nbits;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_n(4);
        chk("rst_miso", 8'(miso), 8'h00);
        chk("rst_oe", 8'(oe), 8'h00);
        chk("rst_wr", 8'(wr), 8'h00);
        chk("rst_wr_addr", 8'(wr_addr), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        for (int i = 0; i < 16; i++) check_reg(4'(i));
        q = {8'h03, 8'h5A, 8'hC3};
        spi_xfer(q, 24, 1'b0, 4'd0, 8'h00);
        check_reg(4'd3);
        check_reg(4'd4);
        loc_write(4'd15, 8'h11);
        loc_write(4'd0, 8'h22);
        q = {8'h8F, 8'h00, 8'h00};
        spi_xfer(q, 24, 1'b0, 4'd0, 8'h00);
        loc_write(4'd2, 8'h3C);
        q = {8'h02, 8'h99};
        spi_xfer(q, 13, 1'b0, 4'd0, 8'h00);
        chk("abort_busy", 8'(busy), 8'h00);
        check_reg(4'd2);
        q = {8'h06, 8'h44};
        spi_xfer(q, 16, 1'b1, 4'd6, 8'hFF);
        check_reg(4'd6);
        q = {8'h07, 8'h33};
        spi_xfer(q, 16, 1'b1, 4'd9, 8'h77);
        check_reg(4'd7);
        check_reg(4'd9);
        repeat (30) begin
            repeat ($urandom_range(0, 2)) loc_write(4'($urandom_range(0, 15)), 8'($urandom));
            cmd = 8'($urandom);
            nb = $urandom_range(1, 3);
            q = {cmd};
            for (int j = 0; j < nb; j++) q.push_back(8'($urandom));
            nbits = 8 * (nb + 1);
            if ($urandom_range(0, 5) == 0) nbits = nbits - $urandom_range(1, 7);
            spi_xfer(q, nbits, 1'b0, 4'd0, 8'h00);
            check_reg(cmd[3:0]);
            check_reg(4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 16; i++) check_reg(4'(i));
        mon_en = 1'b0;
        cs_low();
        cmd = 8'h8F;
        for (int i = 0; i < 11; i++) send_bit(i < 8 ? cmd[7 - i] : 1'b0, 1'b0, 4'd0, 8'h00);
        chk("busy_mid", 8'(busy), 8'h01);
        rst = 1'b1;
        wait_n(3);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            send_bit(1'($urandom), 1'b0, 4'd0, 8'h00);
            chk("post_rst_miso", 8'(miso), 8'h00);
            chk("post_rst_busy", 8'(busy), 8'h00);
        end
        chk("post_rst_oe", 8'(oe), 8'h00);
        cs_high();
        mon_en = 1'b1;
        check_reg(4'd15);
        loc_write(4'd5, 8'h6E);
        q = {8'h85, 8'h00};
        spi_xfer(q, 16, 1'b0, 4'd0, 8'h00);
        wait_n(4);
        chk("miso_pending", 8'(exp_miso.size()), 8'h00);
        chk("wr_pending", 8'(exp_wr.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
